// File: rtl/alu_muldiv.sv
// Single-issue ALU with iterative shift-add multiplier and restoring divider.
// Optional divider is enabled by defining ALU_MULDIV_DIVIDER_EN; without it, ops 12-15 return 0 in one cycle.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             div_zero,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                           OP_SRA = 4'd8, OP_SLTU = 4'd9, OP_MUL = 4'd10, OP_MULHU = 4'd11,
                           OP_DIV = 4'd12, OP_DIVU = 4'd13, OP_REM = 4'd14;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [3:0]       op_r;
    logic [WIDTH-1:0] hi_r, lo_r, m_r, res_r;
    logic             carry_r, ovf_r, zero_r, sign_r, dz_r;
    logic             accept_s, iter_s, last_s;
    logic             sub_s, fast_go_s, fast_c_s, fast_v_s, fast_dz_s;
    logic [WIDTH-1:0] bop_s, fast_res_s, step_hi_s, step_lo_s, fin_res_s;
    logic [WIDTH:0]   sum_s, mul_sum_s;
    logic             wr_en_s, wr_c_s, wr_v_s, wr_dz_s;
    logic [WIDTH-1:0] wr_res_s;
`ifdef ALU_MULDIV_DIVIDER_EN
    logic             neg_q_r, neg_rem_r, is_sdiv_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH:0]   div_sh_s, div_diff_s;
`endif

    assign in_ready  = !rst && ((state_r == S_IDLE) || ((state_r == S_DONE) && out_ready));
    assign accept_s  = in_valid && in_ready;
    assign iter_s    = (state_r == S_MUL) || (state_r == S_DIV);
    assign last_s    = iter_s && (cnt_r == CW'(WIDTH - 1));
    assign out_valid = (state_r == S_DONE);
    assign busy      = iter_s;
    assign result    = res_r;
    assign carry     = carry_r;
    assign overflow  = ovf_r;
    assign zero      = zero_r;
    assign negative  = sign_r;
    assign div_zero  = dz_r;

`ifdef ALU_MULDIV_DIVIDER_EN
    // Operand magnitudes and sign handling for signed division
    always_comb begin
        is_sdiv_s = (op == OP_DIV) || (op == OP_REM);
        a_mag_s   = (is_sdiv_s && a[WIDTH-1]) ? ('0 - a) : a;
        b_mag_s   = (is_sdiv_s && b[WIDTH-1]) ? ('0 - b) : b;
    end
`endif

    // Single-cycle results, plus division special cases that bypass iteration
    always_comb begin
        sub_s      = (op == OP_SUB);
        bop_s      = sub_s ? ~b : b;
        sum_s      = {1'b0, a} + {1'b0, bop_s} + {{WIDTH{1'b0}}, sub_s};
        fast_res_s = '0;
        fast_c_s   = 1'b0;
        fast_v_s   = 1'b0;
        fast_dz_s  = 1'b0;
        fast_go_s  = 1'b1;
        case (op)
            OP_ADD, OP_SUB: begin
                fast_res_s = sum_s[WIDTH-1:0];
                fast_c_s   = sum_s[WIDTH];
                fast_v_s   = (a[WIDTH-1] == bop_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  fast_res_s = a & b;
            OP_OR:   fast_res_s = a | b;
            OP_XOR:  fast_res_s = a ^ b;
            OP_SLT:  fast_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  fast_res_s = a << b[SHW-1:0];
            OP_SRL:  fast_res_s = a >> b[SHW-1:0];
            OP_SRA:  fast_res_s = $unsigned($signed(a) >>> b[SHW-1:0]);
            OP_SLTU: fast_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MUL, OP_MULHU: fast_go_s = 1'b0;
            default: begin
`ifdef ALU_MULDIV_DIVIDER_EN
                if (b == '0) begin
                    fast_dz_s  = 1'b1;
                    fast_res_s = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
                end else if (is_sdiv_s && (a == MIN_NEG) && (b == '1)) begin
                    fast_v_s   = 1'b1;
                    fast_res_s = (op == OP_DIV) ? a : '0;
                end else begin
                    fast_go_s  = 1'b0;
                end
`else
                fast_res_s = '0;
`endif
            end
        endcase
    end

    // One iteration step: shift-add multiply or restoring divide
    always_comb begin
        mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
`ifdef ALU_MULDIV_DIVIDER_EN
        div_sh_s   = {hi_r, lo_r[WIDTH-1]};
        div_diff_s = div_sh_s - {1'b0, m_r};
        if (state_r != S_DIV) begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end else if (div_diff_s[WIDTH]) begin
            step_hi_s = div_sh_s[WIDTH-1:0];
            step_lo_s = {lo_r[WIDTH-2:0], 1'b0};
        end else begin
            step_hi_s = div_diff_s[WIDTH-1:0];
            step_lo_s = {lo_r[WIDTH-2:0], 1'b1};
        end
`else
        step_hi_s = mul_sum_s[WIDTH:1];
        step_lo_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
`endif
    end

    // Final iterative result, including sign restoration for signed division
    always_comb begin
        fin_res_s = step_lo_s;
        if (state_r == S_MUL) begin
            fin_res_s = (op_r == OP_MULHU) ? step_hi_s : step_lo_s;
        end else begin
`ifdef ALU_MULDIV_DIVIDER_EN
            case (op_r)
                OP_DIV:  fin_res_s = neg_q_r ? ('0 - step_lo_s) : step_lo_s;
                OP_DIVU: fin_res_s = step_lo_s;
                OP_REM:  fin_res_s = neg_rem_r ? ('0 - step_hi_s) : step_hi_s;
                default: fin_res_s = step_hi_s;
            endcase
`else
            fin_res_s = step_lo_s;
`endif
        end
    end

    // Select what gets written to the result/flag registers this cycle
    always_comb begin
        wr_en_s  = 1'b0;
        wr_res_s = fast_res_s;
        wr_c_s   = fast_c_s;
        wr_v_s   = fast_v_s;
        wr_dz_s  = fast_dz_s;
        if (accept_s && fast_go_s) begin
            wr_en_s = 1'b1;
        end else if (last_s) begin
            wr_en_s  = 1'b1;
            wr_res_s = fin_res_s;
            wr_c_s   = 1'b0;
            wr_v_s   = 1'b0;
            wr_dz_s  = 1'b0;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Control FSM, iteration datapath and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            op_r    <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            m_r     <= '0;
            res_r   <= '0;
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
            zero_r  <= 1'b0;
            sign_r  <= 1'b0;
            dz_r    <= 1'b0;
`ifdef ALU_MULDIV_DIVIDER_EN
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
`endif
        end else begin
            if (wr_en_s) begin
                res_r   <= wr_res_s;
                carry_r <= wr_c_s;
                ovf_r   <= wr_v_s;
                zero_r  <= (wr_res_s == '0);
                sign_r  <= wr_res_s[WIDTH-1];
                dz_r    <= wr_dz_s;
            end
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (accept_s) begin
                        op_r  <= op;
                        cnt_r <= '0;
                        hi_r  <= '0;
                        if (fast_go_s) begin
                            state_r <= S_DONE;
                        end else if ((op == OP_MUL) || (op == OP_MULHU)) begin
                            lo_r    <= b;
                            m_r     <= a;
                            state_r <= S_MUL;
                        end else begin
`ifdef ALU_MULDIV_DIVIDER_EN
                            lo_r      <= a_mag_s;
                            m_r       <= b_mag_s;
                            neg_q_r   <= is_sdiv_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_r <= is_sdiv_s && a[WIDTH-1];
                            state_r   <= S_DIV;
`else
                            state_r <= S_DONE;
`endif
                        end
                    end else if ((state_r == S_DONE) && out_ready) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_MUL, S_DIV: begin
                    hi_r  <= step_hi_s;
                    lo_r  <= step_lo_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        state_r <= S_DONE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end
endmodule
